// File: rtl/fproc_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package    : fproc_arb_pkg
// Purpose    : shared FSM encoding, error-fill constant and the round-robin
//              index helper used by the fproc arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
package fproc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fproc_arb_state_t;

  localparam int FPROC_ERR_MAX_W = 256;
  localparam logic [FPROC_ERR_MAX_W-1:0] FPROC_ERR_RESULT = '1;

  // Core index reached by stepping 'off' places past 'base', wrapping at n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fproc_rr_arbiter_rr_priority_sel.sv
`default_nettype none
// ============================================================================
// Module     : rr_priority_sel
// Purpose    : combinational round-robin pick of the first request above
//              last_grant, wrapping modulo N_CORES.
// Revision   : 1.0 - initial release
// ============================================================================
module rr_priority_sel
  import fproc_arb_pkg::*;
#(
  parameter int N_CORES = 4
) (
  input  logic [N_CORES-1:0]         req,
  input  logic [$clog2(N_CORES)-1:0] last_grant,
  output logic [$clog2(N_CORES)-1:0] grant,
  output logic                       any_req
);

  localparam int IDX_W = $clog2(N_CORES);

  // Walk from the farthest offset down so the nearest requester is written last.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int k = N_CORES; k >= 1; k--) begin
      if (req[IDX_W'(rr_wrap(int'(last_grant), k, N_CORES))]) begin
        grant   = IDX_W'(rr_wrap(int'(last_grant), k, N_CORES));
        any_req = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fproc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : fproc_rr_arbiter
// Purpose    : round-robin sharing of one fproc backend among N_CORES cores;
//              optional WAIT watchdog enabled by FPROC_ARB_TIMEOUT_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module fproc_rr_arbiter
  import fproc_arb_pkg::*;
#(
  parameter int N_CORES            = 4,
  parameter int FPROC_ID_WIDTH     = 8,
  parameter int FPROC_RESULT_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_CORES-1:0]                    core_en,
  input  logic [N_CORES*FPROC_ID_WIDTH-1:0]     core_id,
  output logic [N_CORES-1:0]                    core_ready,
  output logic [N_CORES*FPROC_RESULT_WIDTH-1:0] core_data,
  output logic                                  fp_enable,
  output logic [FPROC_ID_WIDTH-1:0]             fp_id,
  input  logic                                  fp_ready,
  input  logic [FPROC_RESULT_WIDTH-1:0]         fp_data,
  output logic                                  busy,
  output logic                                  timeout_err
);

  localparam int IDX_W = $clog2(N_CORES);

  fproc_arb_state_t state_q, state_d;

  logic [N_CORES-1:0]            pending_q, pending_d;
  logic [N_CORES-1:0]            accept, clear;
  logic [IDX_W-1:0]              grant_q, last_grant_q, sel_grant;
  logic                          sel_any;
  logic                          load_grant, complete;
  logic [FPROC_RESULT_WIDTH-1:0] resp_data;
  logic [FPROC_ID_WIDTH-1:0]     fp_id_q;
  logic [N_CORES-1:0]            core_ready_q;

  logic [FPROC_ID_WIDTH-1:0]     id_in  [N_CORES];
  logic [FPROC_ID_WIDTH-1:0]     id_q   [N_CORES];
  logic [FPROC_RESULT_WIDTH-1:0] data_q [N_CORES];

`ifdef FPROC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_hit;
  logic             timeout_err_q;
`endif

  for (genvar i = 0; i < N_CORES; i++) begin : g_core
    assign id_in[i] = core_id[i*FPROC_ID_WIDTH +: FPROC_ID_WIDTH];
    assign core_data[i*FPROC_RESULT_WIDTH +: FPROC_RESULT_WIDTH] = data_q[i];
  end

  rr_priority_sel #(
    .N_CORES (N_CORES)
  ) u_sel (
    .req        (pending_q),
    .last_grant (last_grant_q),
    .grant      (sel_grant),
    .any_req    (sel_any)
  );

  always_comb begin
    state_d    = state_q;
    load_grant = 1'b0;
    complete   = 1'b0;
    resp_data  = fp_data;
`ifdef FPROC_ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sel_any) begin
          state_d    = ISSUE;
          load_grant = 1'b1;
        end
      end
      // A result presented while still in ISSUE is deliberately not sampled.
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (fp_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
`ifdef FPROC_ARB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          complete    = 1'b1;
          timeout_hit = 1'b1;
          resp_data   = FPROC_ERR_RESULT[FPROC_RESULT_WIDTH-1:0];
          state_d     = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // A strobe landing on the same edge that retires that core re-arms it.
  always_comb begin
    clear = '0;
    if (complete) clear[grant_q] = 1'b1;
    accept    = core_en & (~pending_q | clear);
    pending_d = (pending_q & ~clear) | accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_CORES - 1);
      fp_id_q      <= '0;
      core_ready_q <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        id_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      core_ready_q <= clear;
      for (int i = 0; i < N_CORES; i++) begin
        if (accept[i]) id_q[i] <= id_in[i];
      end
      if (load_grant) begin
        grant_q <= sel_grant;
        fp_id_q <= id_q[sel_grant];
      end
      if (complete) begin
        data_q[grant_q] <= resp_data;
        last_grant_q    <= grant_q;
      end
    end
  end

`ifdef FPROC_ARB_TIMEOUT_EN
  // Cleared in ISSUE so it reads zero on the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_hit;
      if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      else                 wait_cnt_q <= '0;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_err        = 1'b0;
`endif

  assign fp_enable  = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign fp_id      = fp_id_q;
  assign core_ready = core_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_fproc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_fproc_rr_arbiter
// Purpose    : directed self-checking bench for fproc_rr_arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_fproc_rr_arbiter;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  core_en;
  logic [N*IW-1:0] core_id;
  logic [N-1:0]  core_ready;
  logic [N*RW-1:0] core_data;
  logic          fp_enable;
  logic [IW-1:0] fp_id;
  logic          fp_ready;
  logic [RW-1:0] fp_data;
  logic          busy;
  logic          timeout_err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fproc_rr_arbiter #(
    .N_CORES            (N),
    .FPROC_ID_WIDTH     (IW),
    .FPROC_RESULT_WIDTH (RW),
    .TIMEOUT_CYCLES     (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .core_en     (core_en),
    .core_id     (core_id),
    .core_ready  (core_ready),
    .core_data   (core_data),
    .fp_enable   (fp_enable),
    .fp_id       (fp_id),
    .fp_ready    (fp_ready),
    .fp_data     (fp_data),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  function automatic logic [RW-1:0] cdata(input int i);
    return core_data[i*RW +: RW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; core_en = '0; core_id = '0; fp_ready = 1'b0; fp_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_en(input int max, output bit found, output logic [IW-1:0] id);
    found = 1'b0;
    id    = '0;
    for (int k = 0; k < max; k++) begin
      if (fp_enable === 1'b1) begin
        found = 1'b1;
        id    = fp_id;
        break;
      end
      tick();
    end
  endtask

  // Called in the ISSUE cycle; returns in the cycle after the result edge.
  task automatic respond(input int delay, input logic [RW-1:0] d, input logic [N-1:0] en,
                         input logic [N*IW-1:0] ids, output logic [N-1:0] rdy);
    for (int k = 0; k < delay; k++) tick();
    fp_ready = 1'b1; fp_data = d; core_en = en; core_id = ids;
    tick();
    fp_ready = 1'b0; fp_data = '0; core_en = '0; core_id = '0;
    rdy = core_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1; core_en = '0; core_id = '0; fp_ready = 1'b0; fp_data = '0;
    tick(); tick();
    checks++;
    if ({core_ready, fp_enable, busy, timeout_err} !== 7'd0)
      $display("FAIL reset_ctrl: got %b want 0", {core_ready, fp_enable, busy, timeout_err});
    else passed++;
    checks++;
    if (core_data !== '0) $display("FAIL reset_data: got %h want 0", core_data);
    else passed++;
    checks++;
    if (fp_id !== '0) $display("FAIL reset_fp_id: got %h want 0", fp_id);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [N-1:0] rdy;
    apply_reset();
    core_en = 4'b0010; core_id = 32'h0000_0500;
    tick();
    core_en = '0; core_id = '0;
    checks++;
    if (fp_enable !== 1'b0) $display("FAIL single_early_en: got %b want 0", fp_enable);
    else passed++;
    tick();
    checks++;
    if (fp_enable !== 1'b1) $display("FAIL single_en_t2: got %b want 1", fp_enable);
    else passed++;
    checks++;
    if (fp_id !== 8'h05) $display("FAIL single_fp_id: got %h want 05", fp_id);
    else passed++;
    respond(3, 32'hDEAD_BEEF, '0, '0, rdy);
    checks++;
    if (rdy !== 4'b0010) $display("FAIL single_ready: got %b want 0010", rdy);
    else passed++;
    checks++;
    if (core_data !== {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0})
      $display("FAIL single_data: got %h want %h", core_data, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0});
    else passed++;
    tick();
    checks++;
    if ({core_ready, fp_enable, busy} !== 6'd0)
      $display("FAIL single_after: got %b want 0", {core_ready, fp_enable, busy});
    else passed++;
  endtask

  task automatic test_all_cores();
    int           exp_cyc [4];
    logic [IW-1:0] exp_id [4];
    int           n_en;
    bit           prev_en;
    logic [N-1:0] exp_rdy;
    exp_cyc = '{2, 5, 8, 11};
    exp_id  = '{8'h10, 8'h11, 8'h12, 8'h13};
    n_en    = 0;
    prev_en = 1'b0;
    apply_reset();
    core_en = 4'hF; core_id = 32'h1312_1110;
    for (int k = 1; k <= 14; k++) begin
      tick();
      core_en  = '0; core_id = '0;
      fp_ready = prev_en;
      fp_data  = prev_en ? (32'hA0A0_0000 + RW'(n_en - 1)) : '0;
      if (fp_enable === 1'b1) begin
        if (n_en < 4) begin
          checks++;
          if (k != exp_cyc[n_en]) $display("FAIL all_en_cycle%0d: got %0d want %0d", n_en, k, exp_cyc[n_en]);
          else passed++;
          checks++;
          if (fp_id !== exp_id[n_en]) $display("FAIL all_fp_id%0d: got %h want %h", n_en, fp_id, exp_id[n_en]);
          else passed++;
        end
        n_en++;
      end
      prev_en = (fp_enable === 1'b1);
      exp_rdy = '0;
      for (int j = 0; j < 4; j++) if (k == exp_cyc[j] + 2) exp_rdy = 4'b0001 << j;
      checks++;
      if (core_ready !== exp_rdy) $display("FAIL all_ready_k%0d: got %b want %b", k, core_ready, exp_rdy);
      else passed++;
    end
    fp_ready = 1'b0; fp_data = '0;
    checks++;
    if (n_en != 4) $display("FAIL all_en_count: got %0d want 4", n_en);
    else passed++;
    checks++;
    if (core_data !== {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000})
      $display("FAIL all_data: got %h want A0A00003A0A00002A0A00001A0A00000", core_data);
    else passed++;
  endtask

  task automatic test_rr_order();
    bit           found;
    logic [IW-1:0] id;
    logic [N-1:0] rdy;
    apply_reset();
    core_en = 4'b0010; core_id = 32'h0000_0100;
    tick();
    core_en = '0; core_id = '0;
    wait_en(8, found, id);
    respond(1, 32'h1111_1111, '0, '0, rdy);
    checks++;
    if (!found || rdy !== 4'b0010) $display("FAIL rr_core1: found %b ready %b want 1/0010", found, rdy);
    else passed++;
    core_en = 4'b0101; core_id = 32'h0022_0020;
    tick();
    core_en = 4'b0001; core_id = 32'h0000_0099;
    tick();
    core_en = '0; core_id = '0;
    wait_en(8, found, id);
    checks++;
    if (!found || id !== 8'h22) $display("FAIL rr_first: found %b id %h want 1/22", found, id);
    else passed++;
    respond(1, 32'h2222_2222, '0, '0, rdy);
    checks++;
    if (rdy !== 4'b0100) $display("FAIL rr_first_ready: got %b want 0100", rdy);
    else passed++;
    wait_en(8, found, id);
    checks++;
    if (!found || id !== 8'h20) $display("FAIL rr_second: found %b id %h want 1/20", found, id);
    else passed++;
    respond(2, 32'h3333_3333, '0, '0, rdy);
    checks++;
    if (rdy !== 4'b0001) $display("FAIL rr_second_ready: got %b want 0001", rdy);
    else passed++;
    checks++;
    if (core_data !== {32'h0, 32'h2222_2222, 32'h1111_1111, 32'h3333_3333})
      $display("FAIL rr_data: got %h want 00000000222222221111111133333333", core_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit           found;
    logic [IW-1:0] id;
    logic [N-1:0] rdy;
    apply_reset();
    core_en = 4'b0011; core_id = 32'h0000_3130;
    tick();
    core_en = '0; core_id = '0;
    wait_en(8, found, id);
    checks++;
    if (!found || id !== 8'h30) $display("FAIL b2b_first: found %b id %h want 1/30", found, id);
    else passed++;
    respond(1, 32'h4444_4444, 4'b0001, 32'h0000_0040, rdy);
    checks++;
    if (rdy !== 4'b0001) $display("FAIL b2b_first_ready: got %b want 0001", rdy);
    else passed++;
    tick();
    checks++;
    if (fp_enable !== 1'b1 || fp_id !== 8'h31)
      $display("FAIL b2b_yield: en %b id %h want 1/31", fp_enable, fp_id);
    else passed++;
    respond(1, 32'h5555_5555, '0, '0, rdy);
    checks++;
    if (rdy !== 4'b0010) $display("FAIL b2b_second_ready: got %b want 0010", rdy);
    else passed++;
    wait_en(8, found, id);
    checks++;
    if (!found || id !== 8'h40) $display("FAIL b2b_rearm: found %b id %h want 1/40", found, id);
    else passed++;
    respond(1, 32'h6666_6666, '0, '0, rdy);
    checks++;
    if (rdy !== 4'b0001 || cdata(0) !== 32'h6666_6666)
      $display("FAIL b2b_third: ready %b data %h want 0001/66666666", rdy, cdata(0));
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit           found;
    logic [IW-1:0] id;
    logic [N-1:0] rdy;
    apply_reset();
    core_en = 4'b0001; core_id = 32'h0000_0050;
    tick();
    core_en = '0; core_id = '0;
    wait_en(8, found, id);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (!found || {core_ready, fp_enable, busy, timeout_err} !== 7'd0 || fp_id !== '0 || core_data !== '0)
      $display("FAIL midrst_outputs: found %b ctrl %b id %h data %h want 1/0/0/0",
               found, {core_ready, fp_enable, busy, timeout_err}, fp_id, core_data);
    else passed++;
    fp_ready = 1'b1; fp_data = 32'h1234_5678;
    tick();
    fp_ready = 1'b0; fp_data = '0;
    checks++;
    if (core_ready !== '0 || core_data !== '0 || busy !== 1'b0)
      $display("FAIL midrst_stale_ready: ready %b data %h busy %b want 0/0/0", core_ready, core_data, busy);
    else passed++;
    tick();
    checks++;
    if (fp_enable !== 1'b0 || busy !== 1'b0)
      $display("FAIL midrst_no_reissue: en %b busy %b want 0/0", fp_enable, busy);
    else passed++;
    core_en = 4'b1000; core_id = 32'h5300_0000;
    tick();
    core_en = '0; core_id = '0;
    wait_en(8, found, id);
    checks++;
    if (!found || id !== 8'h53) $display("FAIL midrst_next: found %b id %h want 1/53", found, id);
    else passed++;
    respond(1, 32'h5353_5353, '0, '0, rdy);
    checks++;
    if (rdy !== 4'b1000 || cdata(3) !== 32'h5353_5353)
      $display("FAIL midrst_next_resp: ready %b data %h want 1000/53535353", rdy, cdata(3));
    else passed++;
  endtask

  task automatic test_ready_in_issue();
    bit           found;
    bit           bad;
    logic [IW-1:0] id;
    apply_reset();
    core_en = 4'b0100; core_id = 32'h0060_0000;
    tick();
    core_en = '0; core_id = '0;
    wait_en(8, found, id);
    fp_ready = 1'b1; fp_data = 32'h0BAD_0BAD;
    tick();
    fp_ready = 1'b0; fp_data = '0;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (core_ready !== '0 || busy !== 1'b1) bad = 1'b1;
      tick();
    end
    checks++;
    if (!found || bad || cdata(2) !== '0)
      $display("FAIL issue_ready_ignored: found %b bad %b data %h want 1/0/0", found, bad, cdata(2));
    else passed++;
    fp_ready = 1'b1; fp_data = 32'h0000_600D;
    tick();
    fp_ready = 1'b0; fp_data = '0;
    checks++;
    if (core_ready !== 4'b0100 || cdata(2) !== 32'h0000_600D)
      $display("FAIL issue_late_resp: ready %b data %h want 0100/0000600d", core_ready, cdata(2));
    else passed++;
  endtask

  task automatic test_timeout();
    bit           found;
    bit           bad;
    logic [IW-1:0] id;
    apply_reset();
    core_en = 4'b0010; core_id = 32'h0000_7000;
    tick();
    core_en = '0; core_id = '0;
    wait_en(8, found, id);
    bad = !found;
`ifdef FPROC_ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (core_ready !== '0 || timeout_err !== 1'b0) bad = 1'b1;
    end
    tick();
    checks++;
    if (bad) $display("FAIL tmo_early: premature response or no enable, found %b", found);
    else passed++;
    checks++;
    if (core_ready !== 4'b0010 || timeout_err !== 1'b1 || cdata(1) !== 32'hFFFF_FFFF)
      $display("FAIL tmo_resp: ready %b err %b data %h want 0010/1/ffffffff", core_ready, timeout_err, cdata(1));
    else passed++;
    tick();
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL tmo_after: err %b busy %b want 0/0", timeout_err, busy);
    else passed++;
`else
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (busy !== 1'b1 || core_ready !== '0 || timeout_err !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL wait_forever: busy %b ready %b err %b found %b want 1/0/0/1",
                      busy, core_ready, timeout_err, found);
    else passed++;
    apply_reset();
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_all_cores();
    test_rr_order();
    test_back_to_back();
    test_reset_mid();
    test_ready_in_issue();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
